multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_WAIT, default 1: when 1, FETCH, MEM_READ and MEM_WRITE hold until mem_ready=1; when 0, mem_ready is ignored and each of these states lasts exactly one cycle.
REQ-002 Parameter ILLEGAL_TRAP, default 0: when 1, an unsupported opcode enters HALT; when 0, it is executed as a NOP.
REQ-003 Parameter ALUOP_W, default 3: the width of alu_op; values of 3 or more are legal, and codes are zero-extended.
REQ-004 Port clk, input, 1: the single clock; all state updates occur on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port op, input, 6: opcode from the instruction register, stable from DECODE onward.
REQ-007 Port funct, input, 6: funct field from the instruction register.
REQ-008 Port zero, input, 1: the ALU zero flag.
REQ-009 Port mem_ready, input, 1: memory handshake indicating the current access is complete.
REQ-010 Port pc_write, output, 1: PC load enable.
REQ-011 Port iord, output, 1: memory address select; 0 selects the PC, 1 selects ALUOut.
REQ-012 Port mem_read, output, 1: memory read request.
REQ-013 Port mem_write, output, 1: memory write request.
REQ-014 Port ir_write, output, 1: instruction register load enable.
REQ-015 Port reg_dst, output, 2: destination register select; 0 selects rt, 1 selects rd, 2 selects $ra.
REQ-016 Port mem_to_reg, output, 2: write-back source select; 0 selects ALUOut, 1 selects MDR, 2 selects PC.
REQ-017 Port reg_write, output, 1: register file write enable.
REQ-018 Port alu_src_a, output, 1: ALU A select; 0 selects PC, 1 selects rs.
REQ-019 Port alu_src_b, output, 2: ALU B select; 0 selects rt, 1 selects the constant 4, 2 selects the sign-extended immediate, 3 selects the shifted immediate.
REQ-020 Port alu_op, output, ALUOP_W: ALU operation code.
REQ-021 Port pc_source, output, 2: PC source select; 0 selects the ALU result, 1 selects ALUOut, 2 selects the jump target, 3 selects rs.
REQ-022 Port illegal_op, output, 1: one-cycle flag for an unsupported opcode.
REQ-023 Port state, output, 4: the current state encoding.

Function
REQ-024 States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, JAL=12, JR=13, HALT=15.
REQ-025 The ALU codes shall be: funct-decoded=111, add=100, or=101, and=110, lui=000, sub=001.
REQ-026 In FETCH, the block shall assert mem_read=1 and iord=0 with alu_src_a=0, alu_src_b=1 and alu_op=add; pc_write and ir_write shall assert only in the cycle the fetch completes, and the next state shall be DECODE.
REQ-027 In DECODE, the block shall drive alu_src_a=0, alu_src_b=3 and alu_op=add to precompute the branch target.
REQ-028 DECODE shall dispatch as follows: LW (23h) and SW (2Bh) go to MEM_ADDR; R-type with funct≠08h goes to R_EXEC; R-type with funct=08h goes to JR; BEQ (04h) and BNE (05h) go to BRANCH; J (02h) goes to JUMP; JAL (03h) goes to JAL; ADDI, ORI, ANDI and LUI (08h, 0Dh, 0Ch, 0Fh) go to I_EXEC.
REQ-029 Any other opcode in DECODE shall assert illegal_op for that one cycle, then go to HALT if ILLEGAL_TRAP=1 or to FETCH otherwise.
REQ-030 In MEM_ADDR, the block shall drive alu_src_a=1, alu_src_b=2 and alu_op=add, then go to MEM_READ for LW or MEM_WRITE for SW.
REQ-031 In MEM_READ, the block shall assert mem_read=1 and iord=1, advancing to MEM_WB on completion.
REQ-032 In MEM_WB, the block shall assert reg_write=1 with reg_dst=0 and mem_to_reg=1, then go to FETCH.
REQ-033 In MEM_WRITE, the block shall assert mem_write=1 and iord=1, going to FETCH on completion.
REQ-034 In R_EXEC, the block shall drive alu_src_a=1, alu_src_b=0 and alu_op=111; R_WB shall assert reg_write=1 with reg_dst=1 and mem_to_reg=0.
REQ-035 In I_EXEC, the block shall drive alu_src_a=1, alu_src_b=2 and alu_op per the opcode (add, or, and or lui); I_WB shall assert reg_write=1 with reg_dst=0 and mem_to_reg=0.
REQ-036 In BRANCH, the block shall drive alu_src_a=1, alu_src_b=0, alu_op=sub and pc_source=1, with pc_write=(BEQ&zero)|(BNE&!zero), then go to FETCH.
REQ-037 In JUMP, the block shall assert pc_write=1 with pc_source=2, then go to FETCH.
REQ-038 In JAL, the block shall assert reg_write=1 with reg_dst=2, mem_to_reg=2, pc_write=1 and pc_source=2 in the same cycle, then go to FETCH; the register file shall latch the PC (already PC+4) before the PC updates.
REQ-039 In JR, the block shall assert pc_write=1 with pc_source=3, then go to FETCH.
REQ-040 In HALT, all enables shall be 0 and the block shall remain in HALT until reset.
REQ-041 Latency with no wait states, in cycles: R=4, I=4, LW=5, SW=4, BEQ/BNE=3, J=3, JAL=3, JR=3.
REQ-042 Each wait cycle with mem_ready=0 shall add one cycle, with all outputs held constant and pc_write=ir_write=0.
REQ-043 All outputs shall be Moore outputs decoded from state, op and funct; the only exceptions are pc_write and ir_write in the memory states and pc_write in BRANCH, which also depend on mem_ready or zero.
REQ-044 Any output not listed for a state shall be 0.

Reset
REQ-045 reset=0 shall force the state to FETCH immediately and asynchronously, with every output at its FETCH value except pc_write=ir_write=0, including when reset asserts mid-instruction or during a wait.
REQ-046 After reset deasserts, the first rising edge shall evaluate FETCH normally.

Verification
REQ-047 Reset then ADD (op 00h, funct 20h) with MEM_WAIT=0 -> states 0,1,6,7,0, with reg_write=1 and reg_dst=1 only in state 7.
REQ-048 LW with mem_ready=0 for 2 cycles in MEM_READ -> state 3 for 3 cycles, mem_read held, total 7 cycles, reg_write=1 and mem_to_reg=1 in state 4.
REQ-049 BEQ with zero=1, then BNE with zero=1 -> pc_write=1 in BRANCH for BEQ only, pc_source=1 in both.
REQ-050 JAL (03h) -> states 0,1,12, with reg_write=1, reg_dst=2, mem_to_reg=2, pc_write=1 and pc_source=2 in state 12; JR (00h, funct 08h) -> state 13 with pc_source=3.
REQ-051 op=3Fh with ILLEGAL_TRAP=0 -> illegal_op pulses one cycle, then FETCH; with ILLEGAL_TRAP=1 -> state 15 held, with all enables 0, until reset.
REQ-052 reset pulsed low during MEM_WRITE -> state 0 immediately, mem_write=0 and pc_write=0 with no clock edge.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_control                                           |
// | Description : Main control FSM of a multicycle MIPS-style datapath.        |
// |               Decodes op/funct into per-state datapath controls and        |
// |               sequences memory accesses with an optional ready handshake.  |
// | Ports       : clk        - clock, rising edge active                       |
// |               reset      - asynchronous active-low reset                   |
// |               op, funct  - instruction fields from the IR                  |
// |               zero       - ALU zero flag                                   |
// |               mem_ready  - memory access complete                          |
// |               pc_write, iord, mem_read, mem_write, ir_write, reg_dst,      |
// |               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,         |
// |               pc_source  - datapath controls                               |
// |               illegal_op - one-cycle unsupported-opcode flag               |
// |               state      - current state encoding                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module multicycle_control #(
    parameter int MEM_WAIT     = 1,
    parameter int ILLEGAL_TRAP = 0,
    parameter int ALUOP_W      = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic [3:0]         state
);

    // State encodings
    localparam logic [3:0] c_ST_FETCH     = 4'd0;
    localparam logic [3:0] c_ST_DECODE    = 4'd1;
    localparam logic [3:0] c_ST_MEM_ADDR  = 4'd2;
    localparam logic [3:0] c_ST_MEM_READ  = 4'd3;
    localparam logic [3:0] c_ST_MEM_WB    = 4'd4;
    localparam logic [3:0] c_ST_MEM_WRITE = 4'd5;
    localparam logic [3:0] c_ST_R_EXEC    = 4'd6;
    localparam logic [3:0] c_ST_R_WB      = 4'd7;
    localparam logic [3:0] c_ST_BRANCH    = 4'd8;
    localparam logic [3:0] c_ST_JUMP      = 4'd9;
    localparam logic [3:0] c_ST_I_EXEC    = 4'd10;
    localparam logic [3:0] c_ST_I_WB      = 4'd11;
    localparam logic [3:0] c_ST_JAL       = 4'd12;
    localparam logic [3:0] c_ST_JR        = 4'd13;
    localparam logic [3:0] c_ST_HALT      = 4'd15;

    // Opcodes
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_FN_JR    = 6'h08;

    // ALU operation codes
    localparam logic [2:0] c_ALU_LUI   = 3'b000;
    localparam logic [2:0] c_ALU_SUB   = 3'b001;
    localparam logic [2:0] c_ALU_ADD   = 3'b100;
    localparam logic [2:0] c_ALU_OR    = 3'b101;
    localparam logic [2:0] c_ALU_AND   = 3'b110;
    localparam logic [2:0] c_ALU_FUNCT = 3'b111;

    logic [3:0] r_state;
    logic [3:0] w_nextState;
    logic       w_memDone;
    logic       w_pcWrite;
    logic       w_irWrite;
    logic [2:0] w_aluCode;

    // Without wait states every memory access completes in its first cycle.
    generate
        if (MEM_WAIT != 0) begin : g_memWait
            assign w_memDone = mem_ready;
        end else begin : g_noWait
            assign w_memDone = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_pcWrite   = 1'b0;
        w_irWrite   = 1'b0;
        w_aluCode   = c_ALU_LUI;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_dst     = 2'd0;
        mem_to_reg  = 2'd0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'd0;
        pc_source   = 2'd0;
        illegal_op  = 1'b0;

        case (r_state)
            c_ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                w_aluCode = c_ALU_ADD;
                w_pcWrite = w_memDone;
                w_irWrite = w_memDone;
                if (w_memDone) w_nextState = c_ST_DECODE;
            end
            c_ST_DECODE: begin
                // Branch target precomputed into ALUOut while decoding.
                alu_src_b = 2'd3;
                w_aluCode = c_ALU_ADD;
                case (op)
                    c_OP_LW, c_OP_SW:   w_nextState = c_ST_MEM_ADDR;
                    c_OP_RTYPE:         w_nextState = (funct == c_FN_JR) ? c_ST_JR : c_ST_R_EXEC;
                    c_OP_BEQ, c_OP_BNE: w_nextState = c_ST_BRANCH;
                    c_OP_J:             w_nextState = c_ST_JUMP;
                    c_OP_JAL:           w_nextState = c_ST_JAL;
                    c_OP_ADDI, c_OP_ORI, c_OP_ANDI, c_OP_LUI:
                                        w_nextState = c_ST_I_EXEC;
                    default: begin
                        illegal_op  = 1'b1;
                        w_nextState = (ILLEGAL_TRAP != 0) ? c_ST_HALT : c_ST_FETCH;
                    end
                endcase
            end
            c_ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                w_aluCode = c_ALU_ADD;
                if (op == c_OP_LW)      w_nextState = c_ST_MEM_READ;
                else if (op == c_OP_SW) w_nextState = c_ST_MEM_WRITE;
                else                    w_nextState = c_ST_FETCH;
            end
            c_ST_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (w_memDone) w_nextState = c_ST_MEM_WB;
            end
            c_ST_MEM_WB: begin
                reg_write   = 1'b1;
                mem_to_reg  = 2'd1;
                w_nextState = c_ST_FETCH;
            end
            c_ST_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (w_memDone) w_nextState = c_ST_FETCH;
            end
            c_ST_R_EXEC: begin
                alu_src_a   = 1'b1;
                w_aluCode   = c_ALU_FUNCT;
                w_nextState = c_ST_R_WB;
            end
            c_ST_R_WB: begin
                reg_write   = 1'b1;
                reg_dst     = 2'd1;
                w_nextState = c_ST_FETCH;
            end
            c_ST_BRANCH: begin
                alu_src_a   = 1'b1;
                w_aluCode   = c_ALU_SUB;
                pc_source   = 2'd1;
                w_pcWrite   = ((op == c_OP_BEQ) && zero) || ((op == c_OP_BNE) && !zero);
                w_nextState = c_ST_FETCH;
            end
            c_ST_JUMP: begin
                w_pcWrite   = 1'b1;
                pc_source   = 2'd2;
                w_nextState = c_ST_FETCH;
            end
            c_ST_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                case (op)
                    c_OP_ORI:  w_aluCode = c_ALU_OR;
                    c_OP_ANDI: w_aluCode = c_ALU_AND;
                    c_OP_LUI:  w_aluCode = c_ALU_LUI;
                    default:   w_aluCode = c_ALU_ADD;
                endcase
                w_nextState = c_ST_I_WB;
            end
            c_ST_I_WB: begin
                reg_write   = 1'b1;
                w_nextState = c_ST_FETCH;
            end
            c_ST_JAL: begin
                // PC already holds PC+4, so $ra captures it in the same edge
                // that loads the jump target.
                reg_write   = 1'b1;
                reg_dst     = 2'd2;
                mem_to_reg  = 2'd2;
                w_pcWrite   = 1'b1;
                pc_source   = 2'd2;
                w_nextState = c_ST_FETCH;
            end
            c_ST_JR: begin
                w_pcWrite   = 1'b1;
                pc_source   = 2'd3;
                w_nextState = c_ST_FETCH;
            end
            c_ST_HALT: begin
                w_nextState = c_ST_HALT;
            end
            default: begin
                w_nextState = c_ST_FETCH;
            end
        endcase
    end

    // While reset is held the FSM sits in FETCH; the load enables are
    // masked so that a ready memory cannot update PC or IR during reset.
    assign pc_write = w_pcWrite & reset;
    assign ir_write = w_irWrite & reset;
    assign alu_op   = ALUOP_W'(w_aluCode);
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multicycle_control                                        |
// | Description : Directed self-checking bench for multicycle_control.         |
// |               dut0: MEM_WAIT=0, ILLEGAL_TRAP=0, ALUOP_W=4                  |
// |               dut1: MEM_WAIT=1, ILLEGAL_TRAP=1, ALUOP_W=3                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pcWrite0, iord0, memRead0, memWrite0, irWrite0, regWrite0, aluSrcA0, illegalOp0;
    logic [1:0] regDst0, memToReg0, aluSrcB0, pcSource0;
    logic [3:0] aluOp0, state0;

    logic       pcWrite1, iord1, memRead1, memWrite1, irWrite1, regWrite1, aluSrcA1, illegalOp1;
    logic [1:0] regDst1, memToReg1, aluSrcB1, pcSource1;
    logic [2:0] aluOp1;
    logic [3:0] state1;

    int nChecks = 0;
    int nErrors = 0;

    multicycle_control #(.MEM_WAIT(0), .ILLEGAL_TRAP(0), .ALUOP_W(4)) dut0 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pcWrite0), .iord(iord0), .mem_read(memRead0), .mem_write(memWrite0),
        .ir_write(irWrite0), .reg_dst(regDst0), .mem_to_reg(memToReg0), .reg_write(regWrite0),
        .alu_src_a(aluSrcA0), .alu_src_b(aluSrcB0), .alu_op(aluOp0), .pc_source(pcSource0),
        .illegal_op(illegalOp0), .state(state0)
    );

    multicycle_control #(.MEM_WAIT(1), .ILLEGAL_TRAP(1), .ALUOP_W(3)) dut1 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pcWrite1), .iord(iord1), .mem_read(memRead1), .mem_write(memWrite1),
        .ir_write(irWrite1), .reg_dst(regDst1), .mem_to_reg(memToReg1), .reg_write(regWrite1),
        .alu_src_a(aluSrcA1), .alu_src_b(aluSrcB1), .alu_op(aluOp1), .pc_source(pcSource1),
        .illegal_op(illegalOp1), .state(state1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nErrors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse placed between edges; the next rising edge evaluates FETCH.
    task automatic pulseReset();
        reset = 1'b0;
        #2;
        check("rst_state0", state0, 8'd0);
        check("rst_state1", state1, 8'd0);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        op        = 6'h00;
        funct     = 6'h20;
        zero      = 1'b0;
        mem_ready = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        // Reset state: FETCH values, load enables masked even with ready memory
        check("rst_state", state0, 8'd0);
        check("rst_memread", memRead0, 8'd1);
        check("rst_srcb", aluSrcB0, 8'd1);
        check("rst_aluop", aluOp0, 8'd4);
        mem_ready = 1'b1;
        #1;
        check("rst_pcwrite0", pcWrite0, 8'd0);
        check("rst_irwrite0", irWrite0, 8'd0);
        check("rst_pcwrite1", pcWrite1, 8'd0);
        reset = 1'b1;
        #1;
        check("fetch_pcwrite", pcWrite0, 8'd1);
        check("fetch_irwrite", irWrite0, 8'd1);

        // ADD: 0,1,6,7,0
        tick();
        check("add_s1", state0, 8'd1);
        check("add_dec_srcb", aluSrcB0, 8'd3);
        check("add_dec_regwrite", regWrite0, 8'd0);
        tick();
        check("add_s6", state0, 8'd6);
        check("add_aluop_ext", aluOp0, 8'h07);
        check("add_srca", aluSrcA0, 8'd1);
        check("add_exec_regwrite", regWrite0, 8'd0);
        tick();
        check("add_s7", state0, 8'd7);
        check("add_wb_regwrite", regWrite0, 8'd1);
        check("add_wb_regdst", regDst0, 8'd1);
        tick();
        check("add_s0", state0, 8'd0);
        check("add_end_regwrite", regWrite0, 8'd0);

        // LW on dut1 with two wait cycles in MEM_READ
        pulseReset();
        op = 6'h23;
        mem_ready = 1'b1;
        tick();
        check("lw_s1", state1, 8'd1);
        tick();
        check("lw_s2", state1, 8'd2);
        check("lw_addr_srcb", aluSrcB1, 8'd2);
        mem_ready = 1'b0;
        tick();
        check("lw_s3a", state1, 8'd3);
        check("lw_iord", iord1, 8'd1);
        check("lw_memread_a", memRead1, 8'd1);
        tick();
        check("lw_s3b", state1, 8'd3);
        check("lw_memread_b", memRead1, 8'd1);
        tick();
        check("lw_s3c", state1, 8'd3);
        mem_ready = 1'b1;
        tick();
        check("lw_s4", state1, 8'd4);
        check("lw_regwrite", regWrite1, 8'd1);
        check("lw_memtoreg", memToReg1, 8'd1);
        tick();
        check("lw_s0", state1, 8'd0);

        // BEQ then BNE on dut0
        pulseReset();
        op = 6'h04;
        zero = 1'b1;
        tick();
        tick();
        check("beq_s8", state0, 8'd8);
        check("beq_pcwrite", pcWrite0, 8'd1);
        check("beq_pcsrc", pcSource0, 8'd1);
        check("beq_aluop", aluOp0, 8'd1);
        zero = 1'b0;
        #1;
        check("beq_nz_pcwrite", pcWrite0, 8'd0);
        zero = 1'b1;
        tick();
        check("beq_s0", state0, 8'd0);
        op = 6'h05;
        tick();
        tick();
        check("bne_s8", state0, 8'd8);
        check("bne_pcwrite", pcWrite0, 8'd0);
        check("bne_pcsrc", pcSource0, 8'd1);
        zero = 1'b0;
        #1;
        check("bne_nz_pcwrite", pcWrite0, 8'd1);
        tick();
        check("bne_s0", state0, 8'd0);

        // JAL, JR, J, ORI on dut0
        op = 6'h03;
        tick();
        tick();
        check("jal_s12", state0, 8'd12);
        check("jal_regwrite", regWrite0, 8'd1);
        check("jal_regdst", regDst0, 8'd2);
        check("jal_memtoreg", memToReg0, 8'd2);
        check("jal_pcwrite", pcWrite0, 8'd1);
        check("jal_pcsrc", pcSource0, 8'd2);
        tick();
        op = 6'h00;
        funct = 6'h08;
        tick();
        tick();
        check("jr_s13", state0, 8'd13);
        check("jr_pcsrc", pcSource0, 8'd3);
        check("jr_pcwrite", pcWrite0, 8'd1);
        tick();
        op = 6'h02;
        tick();
        tick();
        check("j_s9", state0, 8'd9);
        check("j_pcsrc", pcSource0, 8'd2);
        tick();
        op = 6'h0D;
        tick();
        tick();
        check("ori_s10", state0, 8'd10);
        check("ori_aluop", aluOp0, 8'd5);
        check("ori_srcb", aluSrcB0, 8'd2);
        tick();
        check("ori_s11", state0, 8'd11);
        check("ori_regwrite", regWrite0, 8'd1);
        check("ori_regdst", regDst0, 8'd0);

        // Illegal opcode: dut0 recovers, dut1 traps in HALT
        pulseReset();
        op = 6'h3F;
        mem_ready = 1'b1;
        tick();
        check("ill_flag0", illegalOp0, 8'd1);
        check("ill_flag1", illegalOp1, 8'd1);
        tick();
        check("ill_s0", state0, 8'd0);
        check("ill_flag0_off", illegalOp0, 8'd0);
        check("ill_s15", state1, 8'd15);
        op = 6'h00;
        funct = 6'h20;
        tick();
        tick();
        check("halt_hold", state1, 8'd15);
        check("halt_pcwrite", pcWrite1, 8'd0);
        check("halt_irwrite", irWrite1, 8'd0);
        check("halt_memread", memRead1, 8'd0);
        check("halt_regwrite", regWrite1, 8'd0);
        check("halt_flag", illegalOp1, 8'd0);

        // SW on dut1, wait in MEM_WRITE, then asynchronous reset
        pulseReset();
        op = 6'h2B;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        check("sw_s5", state1, 8'd5);
        check("sw_memwrite", memWrite1, 8'd1);
        check("sw_iord", iord1, 8'd1);
        tick();
        check("sw_wait_s5", state1, 8'd5);
        check("sw_wait_pcwrite", pcWrite1, 8'd0);
        mem_ready = 1'b1;
        reset = 1'b0;
        #1;
        check("arst_state", state1, 8'd0);
        check("arst_memwrite", memWrite1, 8'd0);
        check("arst_pcwrite", pcWrite1, 8'd0);
        check("arst_irwrite", irWrite1, 8'd0);
        check("arst_memread", memRead1, 8'd1);
        mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        // FETCH waits for memory after reset
        tick();
        check("fetch_wait_s0", state1, 8'd0);
        check("fetch_wait_irwrite", irWrite1, 8'd0);
        mem_ready = 1'b1;
        #1;
        check("fetch_done_irwrite", irWrite1, 8'd1);
        tick();
        check("fetch_done_s1", state1, 8'd1);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
